la_deser: RTL and testbench
===========================

LA_DESER -- requirements
Module: la_deser

Interface
REQ-001 Parameter PROP, default "DEFAULT", SHALL be a technology/property hint with no functional effect.
REQ-002 Parameter N, default 4, SHALL be the deserialisation ratio (bits per output word), legal range 2..32.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 din  input  1  SHALL carry serial data bit, LSB first.
REQ-006 din_valid  input  1  SHALL qualify din and din_first.
REQ-007 din_first  input  1  SHALL mark the bit as bit 0 of a new word.
REQ-008 din_ready  output  1  SHALL indicate the block accepts a serial bit this cycle.
REQ-009 dout  output  N  SHALL carry the assembled parallel word.
REQ-010 dout_valid  output  1  SHALL qualify dout.
REQ-011 dout_ready  input  1  SHALL be the downstream accept.
REQ-012 err  output  1  SHALL pulse one cycle on a framing error.

Function
REQ-013 A serial bit SHALL transfer only when din_valid and din_ready are both high.
REQ-014 The accepted bit with index k (0..N-1) SHALL be stored at dout bit k.
REQ-015 State machine SHALL have states SYNC (waiting for din_first) and SHIFT (collecting bits); reset enters SYNC.
REQ-016 In SYNC, transfers with din_first=0 SHALL be accepted and discarded; a transfer with din_first=1 SHALL store bit 0, set count to 1, and enter SHIFT.
REQ-017 In SHIFT, a transfer with din_first=0 SHALL store bit at index count and increment count.
REQ-018 In SHIFT, a transfer with din_first=1 SHALL discard the partial word, pulse err the next cycle, store the bit as bit 0, set count=1, and stay in SHIFT.
REQ-019 When the N-th bit transfers, the word SHALL move to the output register if it is empty or drained in that same cycle; otherwise it SHALL be held in the shift register. The state SHALL then become SYNC.
REQ-020 A completed word SHALL appear on dout with dout_valid high the cycle after its final bit transfers when the output register is free (latency 1).
REQ-021 dout and dout_valid SHALL hold stable while dout_valid=1 and dout_ready=0.
REQ-022 din_ready SHALL be low only when a completed word is held in the shift register and the output register is full; this state SHALL be reachable only after REQ-019 holding.
REQ-023 When dout_valid and dout_ready are both high and a held word exists, the held word SHALL load into the output register in the same edge, and din_ready SHALL rise the next cycle.
REQ-024 Back-to-back words with dout_ready=1 constantly SHALL sustain one bit per cycle with no bubbles.
REQ-025 err SHALL not assert for din_first arriving exactly at count=0 or in SYNC.

Reset
REQ-026 On rst=1 at a clock edge: state=SYNC, count=0, dout_valid=0, dout=0, err=0, held-word flag=0, and din_ready=1 from the following cycle.
REQ-027 Reset mid-word or with a pending output word SHALL discard all data with no err pulse.

Structure
REQ-028 State encoding (SYNC, SHIFT) and the N range limits SHALL live in a shared la_stdlib package.
REQ-029 Count width SHALL be the ceiling of log2(N+1).
REQ-030 The output register with its valid/ready hold logic SHALL be a sub-module la_pipereg (one-entry valid/ready register, width N).

Verification
REQ-031 N=4, rst, then bits 1,0,1,1 with first on bit 0, dout_ready=1 -> dout=4'b1101, dout_valid high one cycle, latency 1.
REQ-032 Bits sent without din_first after reset -> discarded, no dout_valid, no err.
REQ-033 din_first after 2 bits of a word -> err pulses once; the next 4 bits 0,0,1,0 -> dout=4'b0100.
REQ-034 dout_ready=0, two full words sent -> first held on dout, din_ready low after second word; raise dout_ready -> words delivered in order, din_ready high the next cycle.
REQ-035 rst asserted after 3 bits, with a word pending -> dout_valid=0, err=0, state SYNC; next framed word delivers correctly.
REQ-036 Continuous stream of 8 words with dout_ready=1 -> 8 dout_valid pulses spaced exactly 4 cycles apart.

Source files
------------

// File: rtl/la_stdlib.sv
// Shared definitions for the la_* serial/parallel blocks: deserialiser state
// encoding and the legal range of the deserialisation ratio.
package la_stdlib;

    typedef enum logic {
        SYNC  = 1'b0,
        SHIFT = 1'b1
    } deser_state_t;

    localparam int unsigned N_MIN = 2;
    localparam int unsigned N_MAX = 32;

endpackage

// File: rtl/la_pipereg.sv
// One-entry valid/ready register; accepts a new entry whenever it is empty
// or being drained on the same edge.
module la_pipereg #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/la_deser.sv
// Framed serial-to-parallel converter: LSB-first bits, din_first marks bit 0,
// completed words leave through a one-entry output register.
module la_deser
    import la_stdlib::*;
#(
    parameter string       PROP = "DEFAULT",
    parameter int unsigned N    = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         din,
    input  logic         din_valid,
    input  logic         din_first,
    output logic         din_ready,
    output logic [N-1:0] dout,
    output logic         dout_valid,
    input  logic         dout_ready,
    output logic         err
);

    localparam int unsigned CW = $clog2(N + 1);

    if (N < N_MIN || N > N_MAX) begin : g_bad_n
        $error("la_deser: N out of range");
    end

    deser_state_t   state;
    logic [CW-1:0]  count;
    logic [N-1:0]   sreg;
    logic [N-1:0]   word_next;
    logic           held;
    logic           xfer;
    logic           last_bit;
    logic           pr_in_valid;
    logic           pr_in_ready;
    logic [N-1:0]   pr_in_data;
    int unsigned    idx;

    // A held word only exists while the output register is full, so the held
    // flag alone decides whether another bit can be taken.
    assign din_ready = !held;
    assign xfer      = din_valid && din_ready;
    assign last_bit  = xfer && (state == SHIFT) && !din_first && (count == CW'(N - 1));

    always_comb begin
        word_next = din_first ? '0 : sreg;
        idx       = din_first ? 0 : 32'(count);
        for (int unsigned i = 0; i < N; i++) begin
            if (i == idx) begin
                word_next[i] = din;
            end
        end
        pr_in_valid = held || last_bit;
        pr_in_data  = held ? sreg : word_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SYNC;
            count <= '0;
            sreg  <= '0;
            held  <= 1'b0;
            err   <= 1'b0;
        end else begin
            err <= xfer && din_first && (state == SHIFT);
            if (held && pr_in_ready) begin
                held <= 1'b0;
            end
            if (xfer) begin
                case (state)
                    SYNC: begin
                        if (din_first) begin
                            sreg  <= word_next;
                            count <= CW'(1);
                            state <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        sreg <= word_next;
                        if (din_first) begin
                            count <= CW'(1);
                        end else if (last_bit) begin
                            count <= '0;
                            state <= SYNC;
                            held  <= !pr_in_ready;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    la_pipereg #(
        .W(N)
    ) u_out (
        .clk      (clk),
        .rst      (rst),
        .in_data  (pr_in_data),
        .in_valid (pr_in_valid),
        .in_ready (pr_in_ready),
        .out_data (dout),
        .out_valid(dout_valid),
        .out_ready(dout_ready)
    );

endmodule

// File: tb/tb_la_deser.sv
// Scoreboard bench for la_deser: a frame-level model predicts words, err
// pulses and backpressure; a negedge monitor compares every cycle.
module tb_la_deser;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         din;
    logic         din_valid;
    logic         din_first;
    logic         din_ready;
    logic [N-1:0] dout;
    logic         dout_valid;
    logic         dout_ready;
    logic         err;

    la_deser #(
        .PROP("DEFAULT"),
        .N   (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_first (din_first),
        .din_ready (din_ready),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .err       (err)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference model state
    logic [N-1:0] exp_q[$];
    bit           frame[$];
    bit           in_frame = 1'b0;
    bit           exp_rdy = 1'b1;
    bit           exp_err = 1'b0;
    bit           cur_accept;
    bit           mon_en = 1'b0;
    bit           rec = 1'b0;
    int           cyc = 0;
    int           vcyc[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        frame.delete();
        in_frame = 1'b0;
        exp_err  = 1'b0;
        exp_rdy  = 1'b1;
    endtask

    task automatic model_bit(input bit b, input bit f);
        logic [N-1:0] w;
        exp_err = 1'b0;
        if (f) begin
            exp_err = in_frame && (frame.size() > 0);
            frame.delete();
            frame.push_back(b);
            in_frame = 1'b1;
        end else if (in_frame) begin
            frame.push_back(b);
            if (frame.size() == N) begin
                w = '0;
                foreach (frame[k]) w[k] = frame[k];
                exp_q.push_back(w);
                frame.delete();
                in_frame = 1'b0;
            end
        end
    endtask

    // One clock of stimulus; the model advances at the edge that consumes it.
    task automatic step(input bit v, input bit b, input bit f, input bit rdy, input bit r);
        din_valid  = v;
        din        = b;
        din_first  = f;
        dout_ready = rdy;
        rst        = r;
        cur_accept = v && exp_rdy && !r;
        @(posedge clk);
        if (r) begin
            model_clear();
        end else begin
            if (cur_accept) model_bit(b, f);
            else exp_err = 1'b0;
            exp_rdy = (exp_q.size() < 2);
        end
        #1;
        if (r) check("dout_after_rst", {28'd0, dout}, 32'd0);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, rdy, 1'b0);
    endtask

    task automatic send_bit(input bit b, input bit f, input bit rdy);
        int tries = 0;
        while (!exp_rdy && tries < 50) begin
            step(1'b0, 1'b0, 1'b0, rdy, 1'b0);
            tries++;
        end
        if (!exp_rdy) check("din_ready_timeout", 32'd0, 32'd1);
        step(1'b1, b, f, rdy, 1'b0);
    endtask

    task automatic send_word(input logic [N-1:0] w, input bit rdy);
        for (int k = 0; k < N; k++) send_bit(w[k], k == 0, rdy);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            cyc++;
            check("dout_valid", {31'd0, dout_valid}, {31'd0, exp_q.size() > 0});
            if (exp_q.size() > 0) check("dout", {28'd0, dout}, {28'd0, exp_q[0]});
            check("din_ready", {31'd0, din_ready}, {31'd0, exp_rdy});
            check("err", {31'd0, err}, {31'd0, exp_err});
            if (rec && dout_valid) vcyc.push_back(cyc);
            if (exp_q.size() > 0 && dout_ready && !rst) void'(exp_q.pop_front());
        end
    end

    initial begin
        logic [N-1:0] w;
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        mon_en = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(2, 1'b1);

        // Basic word, latency 1
        send_word(4'b1101, 1'b1);
        idle(3, 1'b1);

        // Unframed bits are dropped silently
        for (int i = 0; i < 6; i++) step(1'b1, i[0], 1'b0, 1'b1, 1'b0);
        idle(2, 1'b1);

        // Re-frame after two bits
        send_bit(1'b1, 1'b1, 1'b1);
        send_bit(1'b1, 1'b0, 1'b1);
        send_word(4'b0100, 1'b1);
        idle(3, 1'b1);

        // Backpressure: two words, then drain
        send_word(4'b1010, 1'b0);
        send_word(4'b0110, 1'b0);
        idle(3, 1'b0);
        idle(4, 1'b1);

        // Reset with a pending word and a partial word
        send_word(4'b1001, 1'b0);
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2, 1'b1);
        send_word(4'b0111, 1'b1);
        idle(3, 1'b1);

        // Back-to-back stream
        vcyc.delete();
        rec = 1'b1;
        for (int i = 0; i < 8; i++) begin
            w = N'($urandom);
            send_word(w, 1'b1);
        end
        idle(3, 1'b1);
        rec = 1'b0;
        check("stream_words", vcyc.size(), 8);
        for (int i = 1; i < vcyc.size(); i++)
            check("stream_spacing", vcyc[i] - vcyc[i-1], 4);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 5) == 0,
                 $urandom_range(0, 9) < 7, $urandom_range(0, 199) == 0);
        end
        idle(6, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
